serial_word_receiver: RTL and testbench
=======================================

# serial_word_receiver

Parametrised serial-to-parallel word receiver for the sonar processor's data input path. It samples an asynchronous bit strobe and data pin, assembles fixed-width words and presents each with a sequential buffer address. A valid/ack handshake delivers words to the memory writer. It adds what the first-generation receiver lacked: input synchronisation, configurable width and bit order, a one-word holding buffer, an inter-bit timeout and overrun detection.

## Interface
- `WORD_W`, 32: bits per word, 2..64.
- `ADDR_W`, 12: width of the word address counter.
- `MSB_FIRST`, 1: 1 means the first received bit lands in bit `WORD_W-1`; 0 means it lands in bit 0.
- `TIMEOUT`, 1023: maximum clk cycles allowed between bit strobes inside a word, 1..65535.
- `clk`, in, 1: sole clock; all state is on the rising edge.
- `reset`, in, 1: asynchronous, active-low.
- `data_pin`, in, 1: serial data, asynchronous to `clk`.
- `data_on_pin`, in, 1: bit strobe, asynchronous; its rising edge marks a valid bit.
- `word_ack`, in, 1: consumer accepts `out`/`addr` in a cycle where `ready` is high.
- `ready`, out, 1: the holding buffer contains a word.
- `out`, out, `WORD_W`: the received word.
- `addr`, out, `ADDR_W`: buffer address of the word in `out`.
- `overrun`, out, 1: sticky; a completed word was dropped.
- `frame_err`, out, 1: one-cycle pulse on a timeout abort or a parity failure.

## Operation
- Reset values: `ready`=0, `out`=0, `addr`=0, `overrun`=0, `frame_err`=0. The shift register, bit counter, timeout counter and address counter all clear. Reset mid-word discards the partial word.
- Synchronisation: both pins pass through a 2-flop synchroniser. A bit is captured when the synchronised strobe is 1 and its previous sample is 0. `data_pin` is taken through the same path, so it must be stable during the strobe's rising edge.
- States: IDLE (bit count 0) and RECV (1..`WORD_W`-1 bits held).
  - The first capture moves IDLE to RECV.
  - The final capture completes the word and returns to IDLE.
- Bit order follows `MSB_FIRST`. The bit counter is `$clog2(WORD_W+1)` bits wide.
- On completion, if the buffer is empty or is acked in the same cycle:
  - `out` loads the word and `addr` loads the address counter.
  - `ready` is set and the address counter increments.
- On completion with `ready`=1 and no ack, the new word is dropped, `overrun` is set and the address does not advance. `overrun` clears only on reset.
- Handshake: `ready` falls the cycle after a `word_ack` if no new word loads at the same time. `word_ack` with `ready`=0 is ignored.
- Address wrap: the counter wraps from 2^`ADDR_W`-1 to 0 with no flag.
- Timeout: in RECV the timeout counter increments each cycle and clears on each capture. When it reaches `TIMEOUT`:
  - the state returns to IDLE and the partial word is discarded;
  - `frame_err` pulses;
  - `addr` and the buffer are untouched.
- If a timeout and a capture occur in the same cycle, the capture wins.

## Timing
- A strobe rising edge that meets setup before clk edge k is captured at edge k+2.
- `ready`/`out`/`addr` update at the same edge that captures the final bit.
- Back-to-back strobes need a gap of at least 2 clk cycles high and 2 cycles low. Faster strobes may lose bits; this is not detected.
- `frame_err` is high for exactly one cycle.

## Configuration
- `SERIAL_WORD_RECEIVER_PARITY_EN` defined:
  - Each frame is `WORD_W`+1 bits; the final bit is even parity over the data bits.
  - On a mismatch the word is discarded, `frame_err` pulses and `addr` does not advance.
  - Timeout also applies before the parity bit.
- Macro undefined: frames are `WORD_W` bits and there is no parity check.

## Structure
- Shared package `sonar_rx_pkg`:
  - the state enum (IDLE, RECV);
  - the default `WORD_W`/`ADDR_W` constants;
  - a parity helper function.
- Sub-module `pin_sync`: 2-flop synchroniser plus rising-edge detector, with outputs `level` and `rise`. It is instantiated once for the strobe; the data pin uses its synchronised level only.

## Test plan
- `WORD_W`=8, `MSB_FIRST`=1: send bits of 0xA5 → `ready`=1, `out`=0xA5, `addr`=0. Ack → `ready`=0. Second word 0x3C → `addr`=1.
- `MSB_FIRST`=0: send 0xA5 LSB first → `out`=0xA5. Same serial stream with `MSB_FIRST`=1 → `out`=0xA5 bit-reversed, i.e. 0xA5.
- Hold `word_ack` low and send 2 words → the first is retained, `overrun`=1, `addr` stays 0. Ack plus a third word 0x11 → `out`=0x11, `addr`=1.
- Send 3 bits then idle for `TIMEOUT` cycles → one-cycle `frame_err`, `ready` stays 0. A following 8 bits of 0xFF → `out`=0xFF.
- `ADDR_W`=2: send 5 words → addresses 0,1,2,3,0. Assert reset in the middle of word 6 → all outputs reset, next word gets `addr`=0.
- Parity build: 0x03 with parity 1 → `frame_err` pulse, no `ready`. 0x03 with parity 0 → accepted.

Source files
------------

// File: rtl/sonar_rx_pkg.sv
// sonar_rx_pkg: shared state enum, default sizes and parity helper for the serial word receiver
package sonar_rx_pkg;
    typedef enum logic {IDLE, RECV} rx_state_t;
    localparam int DEF_WORD_W = 32;
    localparam int DEF_ADDR_W = 12;
    function automatic logic even_parity(input logic [63:0] v);
        return ^v;
    endfunction
endpackage

// File: rtl/pin_sync.sv
// pin_sync: 2-flop synchroniser with rising-edge detect on the synchronised level
module pin_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic level,
    output logic rise
);
    logic [2:0] q;
    always_ff @(posedge clk or negedge reset)
        if (!reset) q <= '0;
        else        q <= {q[1:0], d};
    assign level = q[1];
    assign rise  = q[1] & ~q[2];
endmodule

// File: rtl/serial_word_receiver.sv
// serial_word_receiver: serial-to-parallel word receiver with holding buffer, timeout and overrun;
// defining SERIAL_WORD_RECEIVER_PARITY_EN appends an even-parity bit to each frame
module serial_word_receiver
    import sonar_rx_pkg::*;
#(
    parameter int WORD_W    = DEF_WORD_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter bit MSB_FIRST = 1'b1,
    parameter int TIMEOUT   = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              data_pin,
    input  logic              data_on_pin,
    input  logic              word_ack,
    output logic              ready,
    output logic [WORD_W-1:0] out,
    output logic [ADDR_W-1:0] addr,
    output logic              overrun,
    output logic              frame_err
);
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
    localparam int FRAME_W = WORD_W + 1;
`else
    localparam int FRAME_W = WORD_W;
`endif
    localparam int CW = $clog2(WORD_W + 1);
    localparam logic [CW-1:0] LAST = CW'(FRAME_W - 1);
    localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

    rx_state_t state, state_nx;
    logic [WORD_W-1:0] sr, sr_nx, word;
    logic [CW-1:0] cnt;
    logic [15:0] to_cnt;
    logic [ADDR_W-1:0] addr_cnt;
    logic [1:0] dq;
    logic cap, unused_level, last, done, par_ok, abort, accept, drop;

    pin_sync u_strobe (.clk(clk), .reset(reset), .d(data_on_pin), .level(unused_level), .rise(cap));

    always_comb begin
        sr_nx    = MSB_FIRST ? {sr[WORD_W-2:0], dq[1]} : {dq[1], sr[WORD_W-1:1]};
        last     = cnt == LAST;
        done     = cap && last;
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
        word     = sr;
        par_ok   = even_parity(64'(sr)) == dq[1];
`else
        word     = sr_nx;
        par_ok   = 1'b1;
`endif
        abort    = state == RECV && !cap && to_cnt == TO_LIM;
        accept   = done && par_ok && (!ready || word_ack);
        drop     = done && par_ok && ready && !word_ack;
        state_nx = cap ? (last ? IDLE : RECV) : (abort ? IDLE : state);
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_nx;

    // data is synchronised alongside the strobe so it lines up with the detected rise
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            dq        <= '0;
            sr        <= '0;
            cnt       <= '0;
            to_cnt    <= '0;
            addr_cnt  <= '0;
            ready     <= 1'b0;
            out       <= '0;
            addr      <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            dq        <= {dq[0], data_pin};
            sr        <= (done || abort) ? '0 : cap ? sr_nx : sr;
            cnt       <= (done || abort) ? '0 : cap ? cnt + 1'b1 : cnt;
            to_cnt    <= (state == RECV && !cap && !abort) ? to_cnt + 1'b1 : '0;
            ready     <= accept | (ready & ~word_ack);
            overrun   <= overrun | drop;
            frame_err <= abort | (done & ~par_ok);
            if (accept) begin
                out      <= word;
                addr     <= addr_cnt;
                addr_cnt <= addr_cnt + 1'b1;
            end
        end
endmodule

// File: tb/tb_serial_word_receiver.sv
// tb_serial_word_receiver: random and directed checks of two bit orders against a word-level model
module tb_serial_word_receiver;
    localparam int W = 8, A = 2, TO = 40;
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    logic clk = 0, reset = 1, data_pin = 0, data_on_pin = 0, word_ack = 0;
    logic ready_m, ready_l, overrun_m, overrun_l, fe_m, fe_l;
    logic [W-1:0] out_m, out_l;
    logic [A-1:0] addr_m, addr_l;
    int n_chk = 0, n_pass = 0, fe_m_cnt = 0, fe_l_cnt = 0;
    logic exp_ready = 0, exp_overrun = 0;
    logic [W-1:0] exp_word = 0;
    int exp_addr = 0, next_addr = 0, exp_fe = 0;

    serial_word_receiver #(.WORD_W(W), .ADDR_W(A), .MSB_FIRST(1'b1), .TIMEOUT(TO)) u_msb (
        .clk(clk), .reset(reset), .data_pin(data_pin), .data_on_pin(data_on_pin), .word_ack(word_ack),
        .ready(ready_m), .out(out_m), .addr(addr_m), .overrun(overrun_m), .frame_err(fe_m));
    serial_word_receiver #(.WORD_W(W), .ADDR_W(A), .MSB_FIRST(1'b0), .TIMEOUT(TO)) u_lsb (
        .clk(clk), .reset(reset), .data_pin(data_pin), .data_on_pin(data_on_pin), .word_ack(word_ack),
        .ready(ready_l), .out(out_l), .addr(addr_l), .overrun(overrun_l), .frame_err(fe_l));

    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (fe_m) fe_m_cnt++;
        if (fe_l) fe_l_cnt++;
    end

    function automatic logic [W-1:0] rev(input logic [W-1:0] w);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = w[W-1-i];
        return r;
    endfunction

    function automatic logic [55:0] act_vec();
        return {ready_m, ready_l, overrun_m, overrun_l, addr_m, addr_l, out_m, out_l,
                16'(fe_m_cnt), 16'(fe_l_cnt)};
    endfunction

    // the stream is sent word MSB first, so the LSB-first receiver sees the reversed word
    function automatic logic [55:0] exp_vec();
        return {exp_ready, exp_ready, exp_overrun, exp_overrun, A'(exp_addr), A'(exp_addr),
                exp_word, rev(exp_word), 16'(exp_fe), 16'(exp_fe)};
    endfunction

    task automatic send_bit(input logic b, input logic ack);
        @(negedge clk) data_pin = b;
        @(negedge clk) data_on_pin = 1;
        @(negedge clk);
        @(negedge clk) word_ack = ack;
        @(negedge clk) begin data_on_pin = 0; word_ack = 0; end
        repeat (2) @(negedge clk);
    endtask

    task automatic send_frame(input logic [W-1:0] w, input logic bad_par, input logic ack_last);
        logic p, ok;
        p  = ($countones(w) % 2 == 1) ^ bad_par;
        ok = !(PAR && bad_par);
        for (int i = W - 1; i >= 0; i--) send_bit(w[i], ack_last && i == 0 && !PAR);
        if (PAR) send_bit(p, ack_last);
        if (!ok) begin
            exp_fe++;
            if (ack_last) exp_ready = 0;
        end else if (!exp_ready || ack_last) begin
            exp_ready = 1;
            exp_word  = w;
            exp_addr  = next_addr;
            next_addr = (next_addr + 1) % (1 << A);
        end else exp_overrun = 1;
    endtask

    task automatic ack();
        @(negedge clk) word_ack = 1;
        @(negedge clk) word_ack = 0;
        exp_ready = 0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk) #2 begin reset = 0; data_on_pin = 0; word_ack = 0; end
        exp_ready = 0; exp_overrun = 0; exp_word = 0; exp_addr = 0; next_addr = 0;
        #1 n_chk++;
        if (act_vec() !== exp_vec() || fe_m || fe_l)
            $display("FAIL %s: got %h fe=%b%b want %h fe=00", tag, act_vec(), fe_m, fe_l, exp_vec());
        else n_pass++;
        @(negedge clk) reset = 1;
    endtask

    task automatic test_reset();
        #2 reset = 0;
        #3 n_chk++;
        if (act_vec() !== exp_vec()) $display("FAIL reset: got %h want %h", act_vec(), exp_vec());
        else n_pass++;
        repeat (2) @(negedge clk);
        reset = 1;
    endtask

    task automatic test_basic();
        send_frame(8'hA5, 0, 0);
        n_chk++;
        if (act_vec() !== exp_vec()) $display("FAIL basic_a5: got %h want %h", act_vec(), exp_vec());
        else n_pass++;
        ack();
        n_chk++;
        if (ready_m !== 1'b0 || ready_l !== 1'b0) $display("FAIL ack_drop: got %b%b want 00", ready_m, ready_l);
        else n_pass++;
        send_frame(8'h3C, 0, 0);
        n_chk++;
        if (act_vec() !== exp_vec()) $display("FAIL basic_3c: got %h want %h", act_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_overrun();
        ack();
        send_frame(8'h5A, 0, 0);
        send_frame(8'hC3, 0, 0);
        n_chk++;
        if (act_vec() !== exp_vec()) $display("FAIL overrun: got %h want %h", act_vec(), exp_vec());
        else n_pass++;
        send_frame(8'h11, 0, 1);
        n_chk++;
        if (act_vec() !== exp_vec()) $display("FAIL ack_same_cycle: got %h want %h", act_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_timeout();
        ack();
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        repeat (TO + 10) @(negedge clk);
        exp_fe++;
        n_chk++;
        if (act_vec() !== exp_vec()) $display("FAIL timeout: got %h want %h", act_vec(), exp_vec());
        else n_pass++;
        send_frame(8'hFF, 0, 0);
        n_chk++;
        if (act_vec() !== exp_vec()) $display("FAIL after_timeout: got %h want %h", act_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_parity();
        ack();
        send_frame(8'h03, 1, 0);
        n_chk++;
        if (act_vec() !== exp_vec()) $display("FAIL parity_bad: got %h want %h", act_vec(), exp_vec());
        else n_pass++;
        send_frame(8'h03, 0, 0);
        n_chk++;
        if (act_vec() !== exp_vec()) $display("FAIL parity_good: got %h want %h", act_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_random();
        logic [W-1:0] w;
        for (int n = 0; n < 24; n++) begin
            w = W'($urandom);
            if ($urandom_range(0, 2) == 0) ack();
            send_frame(w, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            n_chk++;
            if (act_vec() !== exp_vec()) $display("FAIL random_%0d: got %h want %h", n, act_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_wrap_reset();
        do_reset("reset_clean");
        for (int n = 0; n < 5; n++) begin
            send_frame(W'(8'h20 + n), 0, 0);
            n_chk++;
            if (act_vec() !== exp_vec()) $display("FAIL wrap_%0d: got %h want %h", n, act_vec(), exp_vec());
            else n_pass++;
            ack();
        end
        send_frame(8'h66, 0, 0);
        send_frame(8'h77, 0, 0);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        do_reset("reset_midword");
        send_frame(8'h99, 0, 0);
        n_chk++;
        if (act_vec() !== exp_vec()) $display("FAIL post_reset: got %h want %h", act_vec(), exp_vec());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_timeout();
        if (PAR) test_parity();
        test_random();
        test_wrap_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
